// File: rtl/det_scan_pkg.sv
// Shared constants for the DET-FF bank scan sequencer: FSM state codes,
// bank reset length and the sample counter width.
package det_scan_pkg;

  // Cycles the DET-FF bank is held in reset after each start
  localparam int CLR_CYC = 2;

  // Width of the free-running sample_clk toggle counter
  localparam int SCNT_W = 16;

  // FSM state encoding, exported on the debug state output
  localparam int ST_W = 3;
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_CLR    = 3'd1;
  localparam logic [ST_W-1:0] ST_WAIT   = 3'd2;
  localparam logic [ST_W-1:0] ST_SETTLE = 3'd3;
  localparam logic [ST_W-1:0] ST_CAP    = 3'd4;
  localparam logic [ST_W-1:0] ST_SCAN   = 3'd5;

endpackage

// File: rtl/det_scan_ctrl_if.sv
// Serial readout port of the DET-FF scan sequencer.
//
// Handshake: a beat transfers on a rising clk edge where out_valid and
// out_ready are both high. While out_valid is high, out_ch, out_data and
// frame_start stay constant until that transfer; out_valid is never withdrawn
// before the transfer, except by reset. out_ready may change freely.
interface det_scan_ctrl_if #(
  parameter int CH_W = 4
) ();
  logic            out_valid;
  logic            out_ready;
  logic            out_data;
  logic [CH_W-1:0] out_ch;
  logic            frame_start;

  modport master (
    output out_valid,
    output out_data,
    output out_ch,
    output frame_start,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_ch,
    input  frame_start,
    output out_ready
  );
endinterface

// File: rtl/det_scan_next_ch.sv
// Priority finder over the channel enable mask: lowest enabled channel, and
// the next enabled channel strictly above the current pointer.
module det_scan_next_ch #(
  parameter int NUM_CH = 16,
  parameter int CH_W   = 4
) (
  input  logic [NUM_CH-1:0] mask,
  input  logic [CH_W-1:0]   ptr,
  output logic [CH_W-1:0]   next_ch,
  output logic [CH_W-1:0]   low_ch,
  output logic              none
);

  // Scan from the top down so the last hit is the lowest qualifying bit
  always_comb begin
    next_ch = '0;
    low_ch  = '0;
    none    = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        low_ch = CH_W'(i);
        if (i > int'(ptr)) begin
          next_ch = CH_W'(i);
          none    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/det_scan_ctrl.sv
// Scan sequencer for the dual-edge sampling flip-flop bank. Generates the
// bank sample clock (one toggle per sample), holds the bank in reset at
// start-up, captures the settled bank outputs and serialises the enabled
// channels onto the readout port. CH_W must satisfy 2**CH_W >= NUM_CH.
module det_scan_ctrl
  import det_scan_pkg::*;
#(
  parameter int NUM_CH     = 16,
  parameter int CH_W       = 4,
  parameter int DIV_W      = 8,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_en,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [NUM_CH-1:0] cfg_ch_mask,
  input  logic [NUM_CH-1:0] ch_data,
  output logic              sample_clk,
  output logic              ff_rstb,
  det_scan_ctrl_if.master   rd,
  output logic              busy,
  output logic              overrun,
  output logic [SCNT_W-1:0] sample_cnt,
  output logic [ST_W-1:0]   dbg_state
);

  localparam logic [2:0] CLR_LAST    = 3'(CLR_CYC - 1);
  localparam logic [2:0] SETTLE_LAST = 3'(SETTLE_CYC - 1);

  logic [ST_W-1:0]   state;
  logic [2:0]        cnt;
  logic [DIV_W-1:0]  div_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_last;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] shadow;
  logic              out_valid_q;
  logic              out_data_q;
  logic              frame_start_q;
  logic [CH_W-1:0]   out_ch_q;
  logic [CH_W-1:0]   next_ch;
  logic [CH_W-1:0]   low_ch;
  logic              next_none;
  logic              running;
  logic              tick;

  // The beat currently on the port doubles as the scan pointer
  det_scan_next_ch #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_next_ch (
    .mask    (mask_q),
    .ptr     (out_ch_q),
    .next_ch (next_ch),
    .low_ch  (low_ch),
    .none    (next_none)
  );

  // Divider runs once the bank is out of reset; a period of 0 acts as 1
  assign running  = (state == ST_WAIT) || (state == ST_SETTLE) ||
                    (state == ST_CAP)  || (state == ST_SCAN);
  assign div_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
  assign tick     = running && (div_cnt == div_last);

  assign busy            = (state != ST_IDLE);
  assign dbg_state       = state;
  assign rd.out_valid    = out_valid_q;
  assign rd.out_data     = out_data_q;
  assign rd.out_ch       = out_ch_q;
  assign rd.frame_start  = frame_start_q;

  // Sample-period divider: wraps on tick, parked at 0 while not running
  always_ff @(posedge clk) begin
    if (rst || !running || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Main sequencer: start-up reset, sampling, capture and readout
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      div_q         <= '0;
      mask_q        <= '0;
      shadow        <= '0;
      sample_clk    <= 1'b0;
      ff_rstb       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= 1'b0;
      out_ch_q      <= '0;
      frame_start_q <= 1'b0;
      overrun       <= 1'b0;
      sample_cnt    <= '0;
    end else begin
      // A tick while a frame is still in flight is a lost sample
      if (tick && (state != ST_WAIT)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          ff_rstb <= 1'b0;
          if (cfg_en) begin
            state   <= ST_CLR;
            cnt     <= '0;
            div_q   <= cfg_div;
            mask_q  <= cfg_ch_mask;
            overrun <= 1'b0;
          end
        end
        ST_CLR: begin
          if (cnt == CLR_LAST) begin
            state   <= ST_WAIT;
            ff_rstb <= 1'b1;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_WAIT: begin
          // Disable wins over a coincident tick so no extra sample is taken
          if (!cfg_en) begin
            state   <= ST_IDLE;
            ff_rstb <= 1'b0;
          end else if (tick) begin
            sample_clk <= ~sample_clk;
            sample_cnt <= sample_cnt + SCNT_W'(1);
            cnt        <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_CAP;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        ST_CAP: begin
          shadow <= ch_data;
          if (mask_q == '0) begin
            state <= ST_WAIT;
          end else begin
            out_ch_q      <= low_ch;
            out_data_q    <= ch_data[low_ch];
            out_valid_q   <= 1'b1;
            frame_start_q <= 1'b1;
            state         <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (out_valid_q && rd.out_ready) begin
            frame_start_q <= 1'b0;
            if (next_none) begin
              out_valid_q <= 1'b0;
              if (cfg_en) begin
                state <= ST_WAIT;
              end else begin
                state   <= ST_IDLE;
                ff_rstb <= 1'b0;
              end
            end else begin
              out_ch_q   <= next_ch;
              out_data_q <= shadow[next_ch];
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_det_scan_ctrl.sv
// Bench for det_scan_ctrl: directed scenarios plus randomised runs, checked
// every cycle against a timeline model of sample ticks, frames and beats.
module tb_det_scan_ctrl;
  import det_scan_pkg::*;

  localparam int NUM_CH     = 16;
  localparam int CH_W       = 4;
  localparam int DIV_W      = 8;
  localparam int SETTLE_CYC = 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_en;
  logic [DIV_W-1:0]  cfg_div;
  logic [NUM_CH-1:0] cfg_ch_mask;
  logic [NUM_CH-1:0] ch_data;
  logic              sample_clk;
  logic              ff_rstb;
  logic              busy;
  logic              overrun;
  logic [15:0]       sample_cnt;
  logic [ST_W-1:0]   dbg_state;

  always #5 clk = ~clk;

  det_scan_ctrl_if #(.CH_W(CH_W)) rd ();

  det_scan_ctrl #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .DIV_W      (DIV_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_en      (cfg_en),
    .cfg_div     (cfg_div),
    .cfg_ch_mask (cfg_ch_mask),
    .ch_data     (ch_data),
    .sample_clk  (sample_clk),
    .ff_rstb     (ff_rstb),
    .rd          (rd),
    .busy        (busy),
    .overrun     (overrun),
    .sample_cnt  (sample_cnt),
    .dbg_state   (dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit rand_mode = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  // Timeline view: a sample is taken every m cycles while waiting; a frame
  // captures the bank SETTLE_CYC cycles after its toggle, then streams the
  // enabled channels in ascending order. Ticks landing inside a frame are lost.
  logic [5:0]  exp_q[$];     // {frame_start, ch, data}
  int          cyc = 0;
  int          phase = 0;    // 0 stopped, 1 bank in start-up reset, 2 sampling
  bit          armed = 1'b0;
  bit          in_frame = 1'b0;
  int          t_start, m, next_tog, v_last, cap_t;
  logic [15:0] mask_m;
  logic        e_sclk = 1'b0;
  logic [15:0] e_cnt = '0;
  logic        e_ovr = 1'b0;

  task automatic end_frame(input int w);
    int d, k;
    in_frame = 1'b0;
    if (v_last + m <= w) e_ovr = 1'b1;
    d = w + 1 - v_last;
    k = (d + m - 1) / m;
    if (k < 1) k = 1;
    next_tog = v_last + k * m;
  endtask

  always @(negedge clk) begin : monitor
    logic ev;
    logic first;
    cyc++;
    if (phase == 1 && cyc == t_start + 1 + CLR_CYC) begin
      phase    = 2;
      in_frame = 1'b0;
      next_tog = cyc + m;
    end
    if (phase == 2 && !in_frame && cyc == next_tog) begin
      e_sclk   = ~e_sclk;
      e_cnt    = e_cnt + 16'd1;
      v_last   = cyc;
      cap_t    = cyc + SETTLE_CYC;
      in_frame = 1'b1;
    end
    ev = in_frame && (exp_q.size() > 0) && (cyc > cap_t);
    if (armed) begin
      check("sample_clk", sample_clk, e_sclk);
      check("sample_cnt", sample_cnt, e_cnt);
      check("ff_rstb", ff_rstb, phase == 2);
      check("busy", busy, phase != 0);
      check("out_valid", rd.out_valid, ev);
      if (ev) check("beat", {rd.frame_start, rd.out_ch, rd.out_data}, exp_q[0]);
      else    check("frame_start_idle", rd.frame_start, 1'b0);
      if (!in_frame) check("overrun", overrun, e_ovr);
    end
    if (rst) begin
      armed    = 1'b1;
      phase    = 0;
      in_frame = 1'b0;
      e_sclk   = 1'b0;
      e_cnt    = '0;
      e_ovr    = 1'b0;
      exp_q.delete();
    end else if (armed) begin
      if (phase == 0) begin
        if (cfg_en) begin
          phase   = 1;
          t_start = cyc;
          m       = (cfg_div == '0) ? 1 : int'(cfg_div);
          mask_m  = cfg_ch_mask;
          e_ovr   = 1'b0;
        end
      end else if (phase == 2) begin
        if (!in_frame) begin
          if (!cfg_en) phase = 0;
        end else if (cyc == cap_t) begin
          first = 1'b1;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            if (mask_m[ch]) begin
              exp_q.push_back({first, CH_W'(ch), ch_data[ch]});
              first = 1'b0;
            end
          end
          if (exp_q.size() == 0) end_frame(cyc + 1);
        end else if (ev && rd.out_ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            end_frame(cyc + 1);
            if (!cfg_en) phase = 0;
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_mode) begin
        ch_data      = 16'($urandom);
        rd.out_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0) begin
          cfg_div     = 8'($urandom);
          cfg_ch_mask = 16'($urandom);
        end
      end
    end
  endtask

  task automatic wait_valid(input int max_cyc);
    int k = 0;
    while (rd.out_valid !== 1'b1 && k < max_cyc) begin
      step(1);
      k++;
    end
    check("wait_valid", rd.out_valid, 1'b1);
  endtask

  task automatic wait_idle(input int max_cyc);
    int k = 0;
    while (busy !== 1'b0 && k < max_cyc) begin
      step(1);
      k++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst          = 1'b1;
    cfg_en       = 1'b0;
    cfg_div      = '0;
    cfg_ch_mask  = '0;
    ch_data      = '0;
    rd.out_ready = 1'b0;

    // Reset values
    step(3);
    check("rst_sample_clk", sample_clk, 1'b0);
    check("rst_ff_rstb", ff_rstb, 1'b0);
    check("rst_out_valid", rd.out_valid, 1'b0);
    check("rst_out_data", rd.out_data, 1'b0);
    check("rst_out_ch", rd.out_ch, '0);
    check("rst_frame_start", rd.frame_start, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    check("rst_sample_cnt", sample_cnt, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    step(1);

    // Basic frame: div 8, channels 0 and 2
    cfg_div = 8'd8; cfg_ch_mask = 16'h0005; ch_data = 16'h0004;
    rd.out_ready = 1'b1; cfg_en = 1'b1;
    step(1);
    check("start_busy", busy, 1'b1);
    check("start_ff_rstb_0", ff_rstb, 1'b0);
    step(1);
    check("start_ff_rstb_1", ff_rstb, 1'b0);
    step(1);
    check("start_ff_rstb_rel", ff_rstb, 1'b1);
    step(7);
    check("pre_toggle_cnt", sample_cnt, 16'd0);
    step(1);
    check("first_toggle_cnt", sample_cnt, 16'd1);
    check("first_toggle_clk", sample_clk, 1'b1);
    step(3);
    check("beat0", {rd.out_valid, rd.frame_start, rd.out_ch, rd.out_data}, {1'b1, 1'b1, 4'd0, 1'b0});
    step(1);
    check("beat1", {rd.out_valid, rd.frame_start, rd.out_ch, rd.out_data}, {1'b1, 1'b0, 4'd2, 1'b1});
    step(1);
    check("frame_end_valid", rd.out_valid, 1'b0);
    step(3);
    check("second_toggle_cnt", sample_cnt, 16'd2);
    step(8);
    check("third_toggle_cnt", sample_cnt, 16'd3);
    cfg_en = 1'b0;
    wait_idle(100);

    // Backpressure on the first beat of a ch0/ch15 frame
    cfg_div = 8'd20; cfg_ch_mask = 16'h8001; ch_data = 16'h8000;
    rd.out_ready = 1'b0; cfg_en = 1'b1;
    wait_valid(60);
    check("bp_first", {rd.frame_start, rd.out_ch, rd.out_data}, {1'b1, 4'd0, 1'b0});
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("bp_hold", {rd.out_valid, rd.out_ch, rd.out_data}, {1'b1, 4'd0, 1'b0});
    end
    rd.out_ready = 1'b1;
    step(1);
    check("bp_ch15", {rd.out_valid, rd.frame_start, rd.out_ch, rd.out_data}, {1'b1, 1'b0, 4'd15, 1'b1});
    step(1);
    check("bp_done", rd.out_valid, 1'b0);
    cfg_en = 1'b0;
    wait_idle(100);

    // Overrun: div 1, all channels
    cfg_div = 8'd1; cfg_ch_mask = 16'hFFFF; ch_data = 16'hA5C3; cfg_en = 1'b1;
    step(40);
    check("ovr_set", overrun, 1'b1);
    cfg_en = 1'b0;
    wait_idle(100);
    check("ovr_sticky", overrun, 1'b1);

    // Zero mask: sampling only, overrun cleared by the restart
    cfg_div = 8'd4; cfg_ch_mask = 16'h0000; cfg_en = 1'b1;
    step(1);
    check("ovr_cleared", overrun, 1'b0);
    step(40);
    check("zero_mask_ovr", overrun, 1'b0);
    cfg_en = 1'b0;
    wait_idle(100);

    // Disable during the second beat of a three-channel frame
    cfg_div = 8'd30; cfg_ch_mask = 16'h0111; ch_data = 16'h0110; cfg_en = 1'b1;
    wait_valid(80);
    check("abort_b0", rd.out_ch, 4'd0);
    step(1);
    check("abort_b1", rd.out_ch, 4'd4);
    cfg_en = 1'b0;
    step(1);
    check("abort_b2", {rd.out_valid, rd.out_ch, rd.out_data}, {1'b1, 4'd8, 1'b1});
    step(1);
    check("abort_idle", {rd.out_valid, busy, ff_rstb}, 3'b000);

    // Randomised runs: config churn, backpressure and random bank data
    for (int s = 0; s < 12; s++) begin
      cfg_div = 8'($urandom_range(0, 24));
      case ($urandom_range(0, 4))
        0:       cfg_ch_mask = '0;
        1:       cfg_ch_mask = 16'(1) << $urandom_range(0, 15);
        default: cfg_ch_mask = 16'($urandom);
      endcase
      cfg_en    = 1'b1;
      rand_mode = 1'b1;
      step($urandom_range(60, 250));
      cfg_en = 1'b0;
      wait_idle(600);
      step($urandom_range(0, 3));
    end
    rand_mode    = 1'b0;

    // Reset in the middle of a beat
    cfg_div = 8'd40; cfg_ch_mask = 16'hFFFF; ch_data = 16'hFFFF;
    rd.out_ready = 1'b0; cfg_en = 1'b1;
    wait_valid(100);
    rd.out_ready = 1'b1;
    step(2);
    rd.out_ready = 1'b0;
    check("pre_rst_ch", rd.out_ch, 4'd2);
    rst = 1'b1; cfg_en = 1'b0;
    step(1);
    check("mid_rst_valid", rd.out_valid, 1'b0);
    check("mid_rst_beat", {rd.frame_start, rd.out_ch, rd.out_data}, 6'd0);
    check("mid_rst_sclk", {sample_clk, ff_rstb, busy, overrun}, 4'b0000);
    check("mid_rst_cnt", sample_cnt, 16'd0);
    rst = 1'b0;
    step(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
